// File: rtl/servo_pkg.sv
// Shared types and constants for the servo motion sequencer.
package servo_pkg;

    localparam int POS_W  = 8;
    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        SETTLE
    } state_e;

    // Clock cycles per PWM frame: in_freq is in MHz, out_freq in Hz.
    function automatic int calc_period(input int in_freq, input int out_freq);
        longint p;
        p = (longint'(in_freq) * longint'(1000000)) / longint'(out_freq);
        return int'(p);
    endfunction

endpackage

// File: rtl/servo_frame_tick.sv
// Free-running frame counter; tick marks the last cycle of each PWM frame.
module servo_frame_tick
    import servo_pkg::*;
#(
    parameter int in_freq  = 50,
    parameter int out_freq = 50
) (
    input  logic Main_clock,
    input  logic reset,
    output logic tick
);

    localparam int PERIOD = calc_period(in_freq, out_freq);
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge Main_clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/servo_motion_sequencer.sv
// Ramps duty_cycle toward commanded targets once per PWM frame, then settles and pulses done.
// Optional target clamping to [POS_MIN, POS_MAX] is enabled with SERVO_SOFT_LIMIT_EN.
module servo_motion_sequencer
    import servo_pkg::*;
#(
    parameter int               in_freq       = 50,
    parameter int               out_freq      = 50,
    parameter logic [POS_W-1:0] HOME_POS      = 8'd128,
    parameter int               SETTLE_FRAMES = 2,
    parameter logic [POS_W-1:0] POS_MIN       = 8'd0,
    parameter logic [POS_W-1:0] POS_MAX       = 8'd255
) (
    input  logic              Main_clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [POS_W-1:0]  cmd_target,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic              hold,
    output logic [POS_W-1:0]  duty_cycle,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] SETTLE_LAST = (SETTLE_FRAMES > 0) ? 4'(SETTLE_FRAMES - 1) : 4'd0;

    logic tick;

    servo_frame_tick #(
        .in_freq (in_freq),
        .out_freq(out_freq)
    ) u_frame_tick (
        .Main_clock(Main_clock),
        .reset     (reset),
        .tick      (tick)
    );

    state_e             state_q, state_d;
    logic [POS_W-1:0]   duty_q, duty_d;
    logic [POS_W-1:0]   target_q, target_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [3:0]         settle_q, settle_d;
    logic               done_q, done_d;
    logic [POS_W-1:0]   tgt_lim;

`ifdef SERVO_SOFT_LIMIT_EN
    assign tgt_lim = (cmd_target < POS_MIN) ? POS_MIN :
                     (cmd_target > POS_MAX) ? POS_MAX : cmd_target;
`else
    logic unused_limits;
    assign unused_limits = ^{POS_MIN, POS_MAX};
    assign tgt_lim = cmd_target;
`endif

    // 9-bit arithmetic so a carry or borrow snaps to the target instead of wrapping.
    logic [POS_W:0]   up_sum, dn_diff;
    logic [POS_W-1:0] up_next, dn_next;
    logic             frame_go;

    always_comb begin
        up_sum   = {1'b0, duty_q} + {5'b0, step_q};
        dn_diff  = {1'b0, duty_q} - {5'b0, step_q};
        up_next  = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[POS_W-1:0];
        dn_next  = (dn_diff[POS_W] || (dn_diff[POS_W-1:0] <= target_q)) ? target_q
                                                                       : dn_diff[POS_W-1:0];
        frame_go = tick && !hold;
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    target_d = tgt_lim;
                    step_d   = (cmd_step == '0) ? 4'd1 : cmd_step;
                    state_d  = MOVE;
                end
            end
            MOVE: begin
                if (frame_go) begin
                    if (duty_q == target_q) begin
                        if (SETTLE_FRAMES == 0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d  = SETTLE;
                            settle_d = 4'd0;
                        end
                    end else if (duty_q < target_q) begin
                        duty_d = up_next;
                    end else begin
                        duty_d = dn_next;
                    end
                end
            end
            SETTLE: begin
                if (frame_go) begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Main_clock) begin
        if (reset) begin
            state_q  <= IDLE;
            duty_q   <= HOME_POS;
            target_q <= '0;
            step_q   <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            settle_q <= settle_d;
            done_q   <= done_d;
        end
    end

    assign duty_cycle = duty_q;
    assign done       = done_q;
    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Scoreboard bench: stimulus pushes expected duty/done events, a negedge monitor pops and compares.
module tb_servo_motion_sequencer;

    localparam int PERIOD = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_target = 8'd0;
    logic [3:0] cmd_step = 4'd0;
    logic       hold = 1'b0;
    logic [7:0] duty_cycle;
    logic       busy;
    logic       done;

    servo_motion_sequencer #(
        .in_freq      (1),
        .out_freq     (100000),
        .HOME_POS     (8'd128),
        .SETTLE_FRAMES(2),
        .POS_MIN      (8'd20),
        .POS_MAX      (8'd255)
    ) dut (
        .Main_clock(clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_target(cmd_target),
        .cmd_step  (cmd_step),
        .hold      (hold),
        .duty_cycle(duty_cycle),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [7:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   started = 1'b0;
    logic [7:0] prev_duty;
    int   fc = 0;
    bit   rst_edge = 1'b1;

    // Reference frame counter: 0 right after a tick edge.
    always @(posedge clk) begin
        rst_edge <= reset;
        if (reset) fc <= 0;
        else       fc <= (fc == PERIOD - 1) ? 0 : fc + 1;
    end

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push_pos(input logic [7:0] v);
        ev_t e;
        e.is_done = 1'b0;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic [7:0] v);
        ev_t e;
        e.is_done = 1'b1;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input bit is_done, input logic [7:0] v);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got done=%0d duty=%0d, expected none", is_done, v);
        end else begin
            e = exp_q.pop_front();
            check(is_done ? "done_kind" : "duty_kind", int'(is_done), int'(e.is_done));
            check(is_done ? "done_duty" : "duty_value", int'(v), int'(e.val));
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (duty_cycle !== prev_duty) begin
                pop_check(1'b0, duty_cycle);
                if (!rst_edge) check("duty_tick_align", fc, 0);
            end
            if (done === 1'b1) begin
                pop_check(1'b1, duty_cycle);
                check("done_tick_align", fc, 0);
            end
        end
        prev_duty = duty_cycle;
    end

    task automatic send(input logic [7:0] t, input logic [3:0] s);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", int'(cmd_ready), 1);
        cmd_target = t;
        cmd_step   = s;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        check("ready_after_accept", int'(cmd_ready), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 400);
        check("done_seen", int'(done), 1);
        check("ready_at_done", int'(cmd_ready), 1);
        check("busy_at_done", int'(busy), 0);
    endtask

    task automatic wait_duty(input logic [7:0] v);
        int n = 0;
        while (duty_cycle !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_duty", int'(duty_cycle), int'(v));
    endtask

    logic [7:0] base;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_duty", int'(duty_cycle), 128);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        started = 1'b1;

        // Upward move, with commands offered while busy that must be ignored.
        push_pos(8'd133); push_pos(8'd138); push_pos(8'd140); push_done(8'd140);
        send(8'd140, 4'd5);
        cmd_target = 8'd0;
        cmd_step   = 4'd15;
        cmd_valid  = 1'b1;
        repeat (5) @(negedge clk);
        check("ready_while_busy", int'(cmd_ready), 0);
        cmd_valid  = 1'b0;
        wait_done();

        // Up to 250, then 250 -> 255 with step 15 must not wrap.
        for (int v = 155; v <= 245; v += 15) push_pos(8'(v));
        push_pos(8'd250); push_done(8'd250);
        send(8'd250, 4'd15);
        wait_done();
        push_pos(8'd255); push_done(8'd255);
        send(8'd255, 4'd15);
        wait_done();

        // Down to 8, then 8 -> 3 with step 10 must not wrap below zero.
        for (int v = 240; v >= 15; v -= 15) push_pos(8'(v));
        push_pos(8'd8); push_done(8'd8);
        send(8'd8, 4'd15);
        wait_done();
        push_pos(8'd3); push_done(8'd3);
        send(8'd3, 4'd10);
        wait_done();

        // Step 0 behaves as step 1.
        push_pos(8'd4); push_pos(8'd5); push_pos(8'd6); push_done(8'd6);
        send(8'd6, 4'd0);
        wait_done();

        // Hold for three frames mid-move.
        for (int v = 10; v <= 30; v += 4) push_pos(8'(v));
        push_done(8'd30);
        send(8'd30, 4'd4);
        wait_duty(8'd14);
        hold = 1'b1;
        repeat (3 * PERIOD) @(negedge clk);
        check("hold_frozen", int'(duty_cycle), 14);
        hold = 1'b0;
        wait_done();

        // Target equal to current position still completes.
        push_done(8'd30);
        send(8'd30, 4'd3);
        wait_done();

        // Target below the soft limit.
`ifdef SERVO_SOFT_LIMIT_EN
        push_pos(8'd20); push_done(8'd20);
        base = 8'd20;
`else
        push_pos(8'd15); push_pos(8'd5); push_done(8'd5);
        base = 8'd5;
`endif
        send(8'd5, 4'd15);
        wait_done();

        // Reset in the middle of a move.
        push_pos(base + 8'd1); push_pos(base + 8'd2);
        send(8'd200, 4'd1);
        wait_duty(base + 8'd2);
        push_pos(8'd128);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_duty", int'(duty_cycle), 128);
        check("midrst_ready", int'(cmd_ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);

        repeat (3 * PERIOD) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
